// File: rtl/riscv_operand_stage_pkg.sv
// Shared constants for the operand stage: operand-source selects and fwd_hits counter helpers.
package riscv_constants;

  localparam int unsigned FWD_HITS_W = 16;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_FOUR = 2'd2
  } op2_sel_e;

  // Add 0..2 forwarded operands to the hit counter, sticking at all-ones.
  function automatic logic [FWD_HITS_W-1:0] sat_add_hits(input logic [FWD_HITS_W-1:0] cnt,
                                                         input logic [1:0]            inc);
    logic [FWD_HITS_W:0] sum;
    sum = {1'b0, cnt} + (FWD_HITS_W+1)'(inc);
    return sum[FWD_HITS_W] ? '1 : sum[FWD_HITS_W-1:0];
  endfunction

endpackage

// File: rtl/riscv_operand_stage_fwd_resolve.sv
// Forwarding lookup for one source operand: lowest-index (youngest) matching producer wins.
// Forwarding is compiled in only with RISCV_OPERAND_FWD_EN; otherwise the register-file value passes through.
module riscv_fwd_resolve
  import riscv_constants::*;
#(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned NUM_FWD     = 2,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input  logic [REG_ADDR_W-1:0]               i_rs_addr,
  input  logic [WORD_LENGTH-1:0]              i_rs_data,
  input  logic [NUM_FWD-1:0]                  i_fwd_valid,
  input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0]  i_fwd_rd,
  input  logic [NUM_FWD-1:0][WORD_LENGTH-1:0] i_fwd_data,
  output logic [WORD_LENGTH-1:0]              o_data_c,
  output logic                                o_hit_c
);

`ifdef RISCV_OPERAND_FWD_EN
  // Scan oldest to youngest so the lowest matching index overrides; x0 never forwards.
  always_comb begin
    o_data_c = i_rs_data;
    o_hit_c  = 1'b0;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (i_fwd_valid[i] && (i_fwd_rd[i] == i_rs_addr) && (i_rs_addr != '0)) begin
        o_data_c = i_fwd_data[i];
        o_hit_c  = 1'b1;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_rs_addr, i_fwd_valid, i_fwd_rd, i_fwd_data};
  assign o_data_c = i_rs_data;
  assign o_hit_c  = 1'b0;
`endif

endmodule

// File: rtl/riscv_operand_stage.sv
// Operand stage: resolves/selects op1/op2 and registers them behind a valid/ready skid-free slot.
// Optional forwarding and fwd_hits counting via RISCV_OPERAND_FWD_EN (default: disabled, fwd_hits stays 0).
module riscv_operand_stage
  import riscv_constants::*;
#(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned NUM_FWD     = 2,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  op1_sel_e                            op1_sel,
  input  op2_sel_e                            op2_sel,
  input  logic [REG_ADDR_W-1:0]               rs1_addr,
  input  logic [REG_ADDR_W-1:0]               rs2_addr,
  input  logic [WORD_LENGTH-1:0]              rs1_data,
  input  logic [WORD_LENGTH-1:0]              rs2_data,
  input  logic [WORD_LENGTH-1:0]              pc,
  input  logic [WORD_LENGTH-1:0]              imm,
  input  logic [NUM_FWD-1:0]                  fwd_valid,
  input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0]  fwd_rd,
  input  logic [NUM_FWD-1:0][WORD_LENGTH-1:0] fwd_data,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WORD_LENGTH-1:0]              op1,
  output logic [WORD_LENGTH-1:0]              op2,
  output logic [FWD_HITS_W-1:0]               fwd_hits
);

  logic                    r_out_valid;
  logic [WORD_LENGTH-1:0]  r_op1;
  logic [WORD_LENGTH-1:0]  r_op2;
  logic [FWD_HITS_W-1:0]   r_fwd_hits;

  logic [WORD_LENGTH-1:0]  w_rs1;
  logic [WORD_LENGTH-1:0]  w_rs2;
  logic                    w_rs1_hit;
  logic                    w_rs2_hit;
  logic [WORD_LENGTH-1:0]  w_op1;
  logic [WORD_LENGTH-1:0]  w_op2;
  logic                    w_op1_fwd;
  logic                    w_op2_fwd;
  logic                    w_load;

  riscv_fwd_resolve #(
    .WORD_LENGTH(WORD_LENGTH), .NUM_FWD(NUM_FWD), .REG_ADDR_W(REG_ADDR_W)
  ) u_rs1_resolve (
    .i_rs_addr  (rs1_addr),
    .i_rs_data  (rs1_data),
    .i_fwd_valid(fwd_valid),
    .i_fwd_rd   (fwd_rd),
    .i_fwd_data (fwd_data),
    .o_data_c   (w_rs1),
    .o_hit_c    (w_rs1_hit)
  );

  riscv_fwd_resolve #(
    .WORD_LENGTH(WORD_LENGTH), .NUM_FWD(NUM_FWD), .REG_ADDR_W(REG_ADDR_W)
  ) u_rs2_resolve (
    .i_rs_addr  (rs2_addr),
    .i_rs_data  (rs2_data),
    .i_fwd_valid(fwd_valid),
    .i_fwd_rd   (fwd_rd),
    .i_fwd_data (fwd_data),
    .o_data_c   (w_rs2),
    .o_hit_c    (w_rs2_hit)
  );

  // Operand muxes; a forward only counts when its register operand is actually selected.
  always_comb begin
    w_op1     = '0;
    w_op1_fwd = 1'b0;
    case (op1_sel)
      OP1_RS1: begin
        w_op1     = w_rs1;
        w_op1_fwd = w_rs1_hit;
      end
      OP1_PC:   w_op1 = pc;
      OP1_ZERO: w_op1 = '0;
      default:  w_op1 = '0;
    endcase
  end

  always_comb begin
    w_op2     = '0;
    w_op2_fwd = 1'b0;
    case (op2_sel)
      OP2_RS2: begin
        w_op2     = w_rs2;
        w_op2_fwd = w_rs2_hit;
      end
      OP2_IMM:  w_op2 = imm;
      OP2_FOUR: w_op2 = WORD_LENGTH'(3'd4);
      default:  w_op2 = '0;
    endcase
  end

  assign in_ready = !r_out_valid || out_ready;
  assign w_load   = in_valid && in_ready && !flush;

  // Flush beats load beats drain; operands only change on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_fwd_hits  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_fwd_hits  <= sat_add_hits(r_fwd_hits, 2'(w_op1_fwd) + 2'(w_op2_fwd));
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign fwd_hits  = r_fwd_hits;

endmodule
